// File: rtl/hdmi_pix_out.sv
// Pixel output stage feeding the ADV7513: FWFT pixel FIFO, frame alignment on a
// start-of-frame tag, and 1-clk delay-matched sync/RGB outputs.
module hdmi_pix_out #(
    parameter int            B         = 8,
    parameter int            ADDR_BITS = 6,
    parameter logic          VS_ACTIVE = 1'b1,
    parameter logic [B-1:0]  FILL_R    = '0,
    parameter logic [B-1:0]  FILL_G    = '0,
    parameter logic [B-1:0]  FILL_B    = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3*B-1:0]       pix_in,
    input  logic                 pix_sof,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 vn_in,
    input  logic                 hn_in,
    input  logic                 dn_in,
    output logic                 vn_out,
    output logic                 hn_out,
    output logic                 den_out,
    output logic [B-1:0]         r_out,
    output logic [B-1:0]         g_out,
    output logic [B-1:0]         b_out,
    output logic [ADDR_BITS:0]   fill_level,
    output logic                 locked,
    output logic                 underflow,
    output logic [15:0]          underflow_cnt
);

    localparam int                 DEPTH    = 2 ** ADDR_BITS;
    localparam int                 W        = 3 * B + 1;
    localparam logic [ADDR_BITS:0] LVL_FULL = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [1:0] S_WAIT_SOF = 2'd0;
    localparam logic [1:0] S_WAIT_VS  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;

    logic [W-1:0]         mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   level_q, level_d;
    logic                 ready_q, ready_d;
    logic [1:0]           state_q, state_d;
    logic                 first_pix_q, first_pix_d;
    logic                 vn_q, vn_d, hn_q, hn_d, den_q, den_d;
    logic [3*B-1:0]       rgb_q, rgb_d;
    logic                 uf_q, uf_d;
    logic [15:0]          ucnt_q, ucnt_d;

    logic [W-1:0]   head;
    logic           head_sof;
    logic [3*B-1:0] head_rgb;
    logic           empty, vs_edge, push, pop, pop_discard, pop_pix;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        head     = mem_q[rd_ptr_q];
        head_sof = head[W-1];
        head_rgb = head[3*B-1:0];
        empty    = (level_q == '0);
        vs_edge  = (vn_in == VS_ACTIVE) && (vn_q != VS_ACTIVE);
        push     = pix_valid && ready_q;

        state_d     = state_q;
        pop_discard = 1'b0;
        pop_pix     = 1'b0;
        uf_d        = uf_q;
        ucnt_d      = ucnt_q;

        case (state_q)
            S_WAIT_SOF: begin
                if (!empty) begin
                    if (head_sof) state_d = S_WAIT_VS;
                    else          pop_discard = 1'b1;
                end
            end
            S_WAIT_VS: begin
                if (vs_edge) state_d = S_LOCKED;
            end
            S_LOCKED: begin
                // Starvation keeps the lock; a tag mismatch means we lost frame alignment.
                if (dn_in) begin
                    if (empty) begin
                        ucnt_d = sat_inc(ucnt_q);
                        uf_d   = 1'b1;
                    end else if (head_sof != first_pix_q) begin
                        uf_d    = 1'b1;
                        state_d = S_WAIT_SOF;
                    end else begin
                        pop_pix = 1'b1;
                    end
                end
            end
            default: state_d = S_WAIT_SOF;
        endcase

        pop      = pop_discard || pop_pix;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LVL_FULL);

        first_pix_d = vs_edge ? 1'b1 : (dn_in ? 1'b0 : first_pix_q);

        vn_d  = vn_in;
        hn_d  = hn_in;
        den_d = dn_in;
        if (!dn_in)       rgb_d = '0;
        else if (pop_pix) rgb_d = head_rgb;
        else              rgb_d = {FILL_R, FILL_G, FILL_B};
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pix_sof, pix_in};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= S_WAIT_SOF;
            first_pix_q <= 1'b0;
            vn_q        <= 1'b0;
            hn_q        <= 1'b0;
            den_q       <= 1'b0;
            rgb_q       <= '0;
            uf_q        <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            state_q     <= state_d;
            first_pix_q <= first_pix_d;
            vn_q        <= vn_d;
            hn_q        <= hn_d;
            den_q       <= den_d;
            rgb_q       <= rgb_d;
            uf_q        <= uf_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign pix_ready     = ready_q;
    assign fill_level    = level_q;
    assign locked        = (state_q == S_LOCKED);
    assign vn_out        = vn_q;
    assign hn_out        = hn_q;
    assign den_out       = den_q;
    assign r_out         = rgb_q[3*B-1:2*B];
    assign g_out         = rgb_q[2*B-1:B];
    assign b_out         = rgb_q[B-1:0];
    assign underflow     = uf_q;
    assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_hdmi_pix_out.sv
// Directed bench for hdmi_pix_out: vector table for the basic flow plus
// hand-written sequences for fill, frame lock, starvation, misalignment and reset.
module tb_hdmi_pix_out;

    logic        clk;
    logic        reset;
    logic [23:0] pix_in;
    logic        pix_sof, pix_valid, pix_ready;
    logic        vn_in, hn_in, dn_in;
    logic        vn_out, hn_out, den_out;
    logic [7:0]  r_out, g_out, b_out;
    logic [6:0]  fill_level;
    logic        locked, underflow;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int errors = 0;
    logic        feed_en;
    logic [24:0] q[$];

    hdmi_pix_out dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_sof(pix_sof),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .vn_in(vn_in), .hn_in(hn_in),
        .dn_in(dn_in), .vn_out(vn_out), .hn_out(hn_out), .den_out(den_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .fill_level(fill_level),
        .locked(locked), .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        sof;
        logic [23:0] rgb;
        logic        vn, hn, dn;
        logic [6:0]  lvl;
        logic        rdy, evn, ehn, eden, lk;
        logic [23:0] ergb;
        logic [15:0] ucnt;
        logic        uf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: feeder presents the queue head, then sample #1 after the edge.
    task automatic step(input logic vn, input logic hn, input logic dn);
        logic acc;
        vn_in = vn;
        hn_in = hn;
        dn_in = dn;
        if (feed_en) begin
            if (q.size() > 0) begin
                pix_valid = 1'b1;
                {pix_sof, pix_in} = q[0];
            end else begin
                pix_valid = 1'b0;
            end
        end
        acc = feed_en && pix_valid && pix_ready;
        @(posedge clk);
        #1;
        if (acc) void'(q.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
        vn_in = 1'b0; hn_in = 1'b0; dn_in = 1'b0;
        q.delete();
        feed_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        logic [15:0] x;
        logic [7:0]  kb;

        tbl[0] = '{1'b1, 1'b0, 24'h111111, 1'b0, 1'b1, 1'b0, 7'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 24'h223344, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 16'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 16'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b0, 7'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h0, 16'd0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 24'h0,      1'b1, 1'b0, 1'b1, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h223344, 16'd0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 16'd1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 24'h0A0B0C, 1'b0, 1'b0, 1'b1, 7'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 16'd2, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0A0B0C, 16'd2, 1'b1};

        // T1: reset values
        reset = 1'b0; feed_en = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0;
        vn_in = 1'b0; hn_in = 1'b0; dn_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t1_rst_outputs", {vn_out, hn_out, den_out, r_out, g_out, b_out, locked, underflow}, 32'h0);
        chk("t1_rst_ready", pix_ready, 1'b0);
        chk("t1_rst_level", fill_level, 7'd0);
        chk("t1_rst_ucnt", underflow_cnt, 16'd0);
        reset = 1'b1;
        #2 chk("t1_ready_before_clk", pix_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("t1_ready_after_clk", pix_ready, 1'b1);
        chk("t1_level_after_clk", fill_level, 7'd0);

        // Table: discard, tag, lock, pop, starve, late pixel
        for (int i = 0; i < 9; i++) begin
            pix_valid = tbl[i].push;
            pix_sof   = tbl[i].sof;
            pix_in    = tbl[i].rgb;
            step(tbl[i].vn, tbl[i].hn, tbl[i].dn);
            chk($sformatf("tab%0d_level", i), fill_level, tbl[i].lvl);
            chk($sformatf("tab%0d_ready", i), pix_ready, tbl[i].rdy);
            chk($sformatf("tab%0d_sync", i), {vn_out, hn_out, den_out}, {tbl[i].evn, tbl[i].ehn, tbl[i].eden});
            chk($sformatf("tab%0d_locked", i), locked, tbl[i].lk);
            chk($sformatf("tab%0d_rgb", i), {r_out, g_out, b_out}, tbl[i].ergb);
            chk($sformatf("tab%0d_ucnt", i), underflow_cnt, tbl[i].ucnt);
            chk($sformatf("tab%0d_uf", i), underflow, tbl[i].uf);
        end

        // T2: fill to DEPTH, refused 65th push, push+pop
        do_reset();
        for (int k = 0; k < 64; k++) begin
            kb = 8'(k);
            q.push_back({(k == 0), kb, 16'h0000});
        end
        repeat (66) step(1'b0, 1'b0, 1'b0);
        chk("t2_level_full", fill_level, 7'd64);
        chk("t2_ready_full", pix_ready, 1'b0);
        q.push_back({1'b0, 24'hAA0000});
        repeat (2) step(1'b0, 1'b0, 1'b0);
        chk("t2_no_65th", fill_level, 7'd64);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_lock", locked, 1'b1);
        chk("t2_lock_level", fill_level, 7'd64);
        step(1'b1, 1'b0, 1'b1);
        chk("t2_first_pop", r_out, 8'h00);
        chk("t2_pop_level", fill_level, 7'd63);
        chk("t2_pop_ready", pix_ready, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("t2_pushpop_r", r_out, 8'h01);
        chk("t2_pushpop_level", fill_level, 7'd63);
        bad = 0;
        for (int k = 2; k < 64; k++) begin
            step(1'b1, 1'b0, 1'b1);
            kb = 8'(k);
            if (r_out !== kb) bad++;
        end
        chk("t2_drain_order", bad, 0);
        step(1'b1, 1'b0, 1'b1);
        chk("t2_late_word", r_out, 8'hAA);
        chk("t2_empty", fill_level, 7'd0);

        // T3: untagged junk, tagged 1280-pixel line, lock on first vs edge
        do_reset();
        for (int i = 0; i < 3; i++) q.push_back({1'b0, 24'hEEEEEE});
        for (int i = 0; i < 1280; i++) begin
            x = 16'(i);
            q.push_back({(i == 0), x[7:0], x[15:8], 8'h5A});
        end
        repeat (20) step(1'b0, 1'b0, 1'b0);
        chk("t3_prelock", locked, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t3_locked", locked, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 1280; i++) begin
            step(1'b0, 1'b0, 1'b1);
            x = 16'(i);
            if (i == 0) chk("t3_first_pix", {den_out, r_out, g_out, b_out}, {1'b1, 24'h00005A});
            if (i == 1279) chk("t3_last_pix", {den_out, r_out}, {1'b1, 8'hFF});
            if (r_out !== x[7:0] || g_out !== x[15:8] || den_out !== 1'b1) bad++;
        end
        step(1'b0, 1'b1, 1'b0);
        chk("t3_line_data", bad, 0);
        chk("t3_no_underflow", {underflow, underflow_cnt}, 17'd0);
        chk("t3_blank_rgb", {den_out, r_out}, 9'd0);

        // T4: starve 10 active pixels mid-line
        for (int i = 0; i < 30; i++) q.push_back({1'b0, 8'(8'h80 + i), 16'h1122});
        repeat (35) step(1'b0, 1'b0, 1'b0);
        chk("t4_prefill", fill_level, 7'd30);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (i < 30 && r_out !== 8'(8'h80 + i)) bad++;
            if (i >= 30 && {r_out, g_out, b_out} !== 24'h0) bad++;
        end
        chk("t4_pix_then_fill", bad, 0);
        chk("t4_ucnt", underflow_cnt, 16'd10);
        chk("t4_uf", underflow, 1'b1);
        chk("t4_locked", locked, 1'b1);
        for (int i = 0; i < 5; i++) q.push_back({1'b0, 8'(8'hC0 + i), 16'h0000});
        repeat (8) step(1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (r_out !== 8'(8'hC0 + i)) bad++;
        end
        chk("t4_resume", bad, 0);
        chk("t4_ucnt_hold", underflow_cnt, 16'd10);

        // T5: stray sof on the 100th pixel, relock next frame
        for (int i = 0; i < 99; i++) q.push_back({1'b0, 8'(i + 1), 16'h0000});
        q.push_back({1'b1, 24'h556677});
        for (int i = 0; i < 20; i++) q.push_back({1'b0, 8'(8'h60 + i), 16'h0000});
        repeat (70) step(1'b0, 1'b0, 1'b0);
        chk("t5_prefill", fill_level, 7'd64);
        bad = 0;
        for (int i = 0; i < 110; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (i < 99 && r_out !== 8'(i + 1)) bad++;
            if (i == 99) begin
                chk("t5_fill_at_sof", {r_out, g_out, b_out}, 24'h0);
                chk("t5_unlocked", locked, 1'b0);
            end
            if (i > 99 && {r_out, g_out, b_out} !== 24'h0) bad++;
        end
        chk("t5_line", bad, 0);
        chk("t5_ucnt_hold", underflow_cnt, 16'd10);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        chk("t5_wait_vs", locked, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_relock", locked, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_sof_pix", {r_out, g_out, b_out}, 24'h556677);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_next_pix", r_out, 8'h60);

        // T6: asynchronous reset mid-line at fill level 40
        do_reset();
        q.push_back({1'b1, 24'h010203});
        for (int i = 0; i < 40; i++) q.push_back({1'b0, 8'(i + 2), 16'h0000});
        repeat (45) step(1'b0, 1'b0, 1'b0);
        chk("t6_level41", fill_level, 7'd41);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t6_level40", fill_level, 7'd40);
        chk("t6_active", {vn_out, hn_out, den_out, r_out, g_out, b_out}, {3'b111, 24'h010203});
        #2 reset = 1'b0;
        #1;
        chk("t6_async_level", fill_level, 7'd0);
        chk("t6_async_outputs", {vn_out, hn_out, den_out, r_out, g_out, b_out, locked, pix_ready}, 32'h0);
        chk("t6_async_uf", {underflow, underflow_cnt}, 17'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
